rob_unit: RTL and testbench

- 32-entry reorder buffer for the out-of-order MIPS core.
- Dispatch allocates the entry addressed by an externally supplied 5-bit tag.
- The CDB marks entries complete. Entries retire in order from a head pointer.
- A 32-entry register status table renames Rs/Rt reads to ROB tokens and returns speculative data when the producing entry is complete.

---
 rtl/rob_unit.sv | 166 ++++++++++++++++
 tb/tb_rob_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_unit.sv
// Reorder buffer: tag-addressed dispatch, CDB completion, in-order retire, register-status renaming.
// Latency: retire and lookups are combinational; CDB results reach lookups next cycle (same cycle under ROB_CDB_BYPASS_EN).
// Backpressure: none; the external tag allocator must keep at most DEPTH entries outstanding.
module rob_unit #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(NREG)-1:0]    Rs_reg,
  input  logic                       Rs_reg_ren,
  output logic [$clog2(DEPTH):0]     Rs_token,
  output logic [DATA_W-1:0]          Rs_Data_spec,
  output logic                       Rs_Data_valid,
  input  logic [$clog2(NREG)-1:0]    Rt_reg,
  input  logic                       Rt_reg_ren,
  output logic [$clog2(DEPTH):0]     Rt_token,
  output logic [DATA_W-1:0]          Rt_Data_spec,
  output logic                       Rt_Data_valid,
  input  logic [$clog2(DEPTH)-1:0]   Dispatch_Rd_tag,
  input  logic [$clog2(NREG)-1:0]    Dispatch_Rd_reg,
  input  logic [DATA_W-1:0]          Dispatch_pc,
  input  logic [1:0]                 Dispatch_inst_type,
  input  logic [$clog2(DEPTH)-1:0]   Cdb_rd_tag,
  input  logic                       Cdb_valid,
  input  logic [DATA_W-1:0]          Cdb_data,
  input  logic                       Cdb_branch,
  input  logic                       Cdb_branch_taken,
  output logic [$clog2(DEPTH)-1:0]   Retire_rd_tag,
  output logic [$clog2(NREG)-1:0]    Retire_rd_reg,
  output logic [DATA_W-1:0]          Retire_data,
  output logic [DATA_W-1:0]          Retire_pc,
  output logic                       Retire_branch,
  output logic                       Retire_branch_taken,
  output logic                       Retire_store_ready,
  output logic                       Retire_valid
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int REG_W = $clog2(NREG);
  localparam logic [1:0] TYPE_NONE  = 2'b00;
  localparam logic [1:0] TYPE_STORE = 2'b10;
  localparam logic [1:0] TYPE_REG   = 2'b11;

  typedef struct packed {
    logic [TAG_W:0]    token;
    logic [DATA_W-1:0] data;
    logic              vld;
  } lookup_t;

  logic [DEPTH-1:0]  ent_valid, ent_done, ent_branch, ent_taken;
  logic [REG_W-1:0]  ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_pc   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [1:0]        ent_type [DEPTH];
  logic [NREG-1:0]   st_pend;
  logic [TAG_W-1:0]  st_tag   [NREG];
  logic [TAG_W-1:0]  head;
  logic              retire_fire;
  logic              dispatch_fire;
  lookup_t           rs_res, rt_res;

  assign retire_fire   = ent_valid[head] & ent_done[head];
  assign dispatch_fire = (Dispatch_inst_type != TYPE_NONE);

  // Retire clears first so a same-cycle dispatch to the head tag wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid  <= '0;
      ent_done   <= '0;
      ent_branch <= '0;
      ent_taken  <= '0;
      head       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_pc[i]   <= '0;
        ent_data[i] <= '0;
        ent_type[i] <= TYPE_NONE;
      end
    end else begin
      if (retire_fire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + TAG_W'(1);
      end
      if (Cdb_valid && ent_valid[Cdb_rd_tag]) begin
        ent_done[Cdb_rd_tag]   <= 1'b1;
        ent_data[Cdb_rd_tag]   <= Cdb_data;
        ent_branch[Cdb_rd_tag] <= Cdb_branch;
        ent_taken[Cdb_rd_tag]  <= Cdb_branch_taken;
      end
      if (dispatch_fire) begin
        ent_valid[Dispatch_Rd_tag] <= 1'b1;
        ent_done[Dispatch_Rd_tag]  <= 1'b0;
        ent_rd[Dispatch_Rd_tag]    <= Dispatch_Rd_reg;
        ent_pc[Dispatch_Rd_tag]    <= Dispatch_pc;
        ent_type[Dispatch_Rd_tag]  <= Dispatch_inst_type;
      end
    end
  end

  // A retiring producer only clears the mapping if no younger producer has replaced it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_pend <= '0;
      for (int r = 0; r < NREG; r++) st_tag[r] <= '0;
    end else begin
      if (retire_fire && ent_type[head] == TYPE_REG && st_tag[ent_rd[head]] == head)
        st_pend[ent_rd[head]] <= 1'b0;
      if (Dispatch_inst_type == TYPE_REG && Dispatch_Rd_reg != '0) begin
        st_pend[Dispatch_Rd_reg] <= 1'b1;
        st_tag[Dispatch_Rd_reg]  <= Dispatch_Rd_tag;
      end
    end
  end

  function automatic lookup_t do_lookup(input logic [REG_W-1:0] r, input logic ren);
    lookup_t          res;
    logic [TAG_W-1:0] t;
    res = '0;
    t   = st_tag[r];
    if (ren && st_pend[r]) begin
      res.token = {1'b1, t};
      if (ent_done[t]) begin
        res.data = ent_data[t];
        res.vld  = 1'b1;
      end
`ifdef ROB_CDB_BYPASS_EN
      else if (Cdb_valid && Cdb_rd_tag == t && ent_valid[t]) begin
        res.data = Cdb_data;
        res.vld  = 1'b1;
      end
`endif
    end
    return res;
  endfunction

  assign rs_res        = do_lookup(Rs_reg, Rs_reg_ren);
  assign rt_res        = do_lookup(Rt_reg, Rt_reg_ren);
  assign Rs_token      = rs_res.token;
  assign Rs_Data_spec  = rs_res.data;
  assign Rs_Data_valid = rs_res.vld;
  assign Rt_token      = rt_res.token;
  assign Rt_Data_spec  = rt_res.data;
  assign Rt_Data_valid = rt_res.vld;

  always_comb begin
    Retire_rd_tag       = '0;
    Retire_rd_reg       = '0;
    Retire_data         = '0;
    Retire_pc           = '0;
    Retire_branch       = 1'b0;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = 1'b0;
    Retire_valid        = 1'b0;
    if (retire_fire) begin
      Retire_rd_tag       = head;
      Retire_rd_reg       = ent_rd[head];
      Retire_data         = ent_data[head];
      Retire_pc           = ent_pc[head];
      Retire_branch       = ent_branch[head];
      Retire_branch_taken = ent_taken[head];
      Retire_store_ready  = (ent_type[head] == TYPE_STORE);
      Retire_valid        = 1'b1;
    end
  end
endmodule

// File: tb/tb_rob_unit.sv
// Bench for rob_unit: directed scenarios plus a randomized run against an in-order queue model.
module tb_rob_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  Rs_reg, Rt_reg;
  logic        Rs_reg_ren, Rt_reg_ren;
  logic [5:0]  Rs_token, Rt_token;
  logic [31:0] Rs_Data_spec, Rt_Data_spec;
  logic        Rs_Data_valid, Rt_Data_valid;
  logic [4:0]  Dispatch_Rd_tag, Dispatch_Rd_reg;
  logic [31:0] Dispatch_pc;
  logic [1:0]  Dispatch_inst_type;
  logic [4:0]  Cdb_rd_tag;
  logic        Cdb_valid, Cdb_branch, Cdb_branch_taken;
  logic [31:0] Cdb_data;
  logic [4:0]  Retire_rd_tag, Retire_rd_reg;
  logic [31:0] Retire_data, Retire_pc;
  logic        Retire_branch, Retire_branch_taken, Retire_store_ready, Retire_valid;

  int checks = 0;
  int errors = 0;

  rob_unit dut (
    .clock(clock), .reset(reset),
    .Rs_reg(Rs_reg), .Rs_reg_ren(Rs_reg_ren), .Rs_token(Rs_token),
    .Rs_Data_spec(Rs_Data_spec), .Rs_Data_valid(Rs_Data_valid),
    .Rt_reg(Rt_reg), .Rt_reg_ren(Rt_reg_ren), .Rt_token(Rt_token),
    .Rt_Data_spec(Rt_Data_spec), .Rt_Data_valid(Rt_Data_valid),
    .Dispatch_Rd_tag(Dispatch_Rd_tag), .Dispatch_Rd_reg(Dispatch_Rd_reg),
    .Dispatch_pc(Dispatch_pc), .Dispatch_inst_type(Dispatch_inst_type),
    .Cdb_rd_tag(Cdb_rd_tag), .Cdb_valid(Cdb_valid), .Cdb_data(Cdb_data),
    .Cdb_branch(Cdb_branch), .Cdb_branch_taken(Cdb_branch_taken),
    .Retire_rd_tag(Retire_rd_tag), .Retire_rd_reg(Retire_rd_reg),
    .Retire_data(Retire_data), .Retire_pc(Retire_pc),
    .Retire_branch(Retire_branch), .Retire_branch_taken(Retire_branch_taken),
    .Retire_store_ready(Retire_store_ready), .Retire_valid(Retire_valid)
  );

  always #5 clock = ~clock;

  // Reference: in-flight instructions in program order; the oldest is the retire candidate.
  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  ty;
    logic        done;
    logic [31:0] data;
    logic        br;
    logic        tk;
  } rec_t;
  rec_t       q[$];
  logic [4:0] next_tag;

  function automatic void m_lookup(input logic [4:0] r, input logic ren,
                                   output logic [5:0] tok, output logic [31:0] d, output logic v);
    bit found;
    tok = '0; d = '0; v = 1'b0; found = 0;
    if (ren && r != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!found && q[i].ty == 2'b11 && q[i].rd == r) begin
          found = 1;
          tok = {1'b1, q[i].tag};
          if (q[i].done) begin
            d = q[i].data; v = 1'b1;
          end
`ifdef ROB_CDB_BYPASS_EN
          else if (Cdb_valid && Cdb_rd_tag == q[i].tag) begin
            d = Cdb_data; v = 1'b1;
          end
`endif
        end
      end
    end
  endfunction

  function automatic logic [77:0] m_retire();
    if (q.size() > 0 && q[0].done)
      return {q[0].tag, q[0].rd, q[0].data, q[0].pc, q[0].br, q[0].tk, (q[0].ty == 2'b10), 1'b1};
    return '0;
  endfunction

  function automatic logic [77:0] dut_retire();
    return {Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc, Retire_branch,
            Retire_branch_taken, Retire_store_ready, Retire_valid};
  endfunction

  task automatic idle_inputs();
    Rs_reg = '0; Rs_reg_ren = 0; Rt_reg = '0; Rt_reg_ren = 0;
    Dispatch_Rd_tag = '0; Dispatch_Rd_reg = '0; Dispatch_pc = '0; Dispatch_inst_type = 2'b00;
    Cdb_rd_tag = '0; Cdb_valid = 0; Cdb_data = '0; Cdb_branch = 0; Cdb_branch_taken = 0;
  endtask

  task automatic tick();
    bit   ret;
    rec_t r;
    @(posedge clock);
    ret = (q.size() > 0 && q[0].done);
    if (Cdb_valid)
      foreach (q[i])
        if (q[i].tag == Cdb_rd_tag) begin
          q[i].done = 1'b1; q[i].data = Cdb_data; q[i].br = Cdb_branch; q[i].tk = Cdb_branch_taken;
        end
    if (ret) void'(q.pop_front());
    if (Dispatch_inst_type != 2'b00) begin
      r.tag = Dispatch_Rd_tag; r.rd = Dispatch_Rd_reg; r.pc = Dispatch_pc; r.ty = Dispatch_inst_type;
      r.done = 1'b0; r.data = '0; r.br = 1'b0; r.tk = 1'b0;
      q.push_back(r);
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    q.delete();
    next_tag = '0;
  endtask

  task automatic dispatch(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] pc, input logic [1:0] ty);
    idle_inputs();
    Dispatch_Rd_tag = tag; Dispatch_Rd_reg = rd; Dispatch_pc = pc; Dispatch_inst_type = ty;
    tick();
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] d, input logic br, input logic tk);
    idle_inputs();
    Cdb_rd_tag = tag; Cdb_valid = 1; Cdb_data = d; Cdb_branch = br; Cdb_branch_taken = tk;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    Rs_reg = 5'd5; Rs_reg_ren = 1;
    settle();
    checks++; if (Rs_token !== 6'h00) begin errors++; $display("FAIL reset_rs_token: got %h expected 00", Rs_token); end
    checks++; if (Rs_Data_valid !== 1'b0) begin errors++; $display("FAIL reset_rs_valid: got %b expected 0", Rs_Data_valid); end
    checks++; if (dut_retire() !== 78'd0) begin errors++; $display("FAIL reset_retire: got %h expected 0", dut_retire()); end
  endtask

  task automatic test_dispatch_lookup();
    dispatch(5'd3, 5'd7, 32'd12, 2'b11);
    idle_inputs();
    Rs_reg = 5'd7; Rs_reg_ren = 1;
    settle();
    checks++; if (Rs_token !== 6'h23) begin errors++; $display("FAIL dispatch_token: got %h expected 23", Rs_token); end
    checks++; if (Rs_Data_valid !== 1'b0) begin errors++; $display("FAIL dispatch_valid: got %b expected 0", Rs_Data_valid); end
  endtask

  task automatic test_cdb_forward();
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(5'(i), 5'(i + 1), 32'(4 * i), 2'b11);
    cdb(5'd2, 32'd20, 0, 0);
    idle_inputs();
    Rs_reg = 5'd3; Rs_reg_ren = 1;
    settle();
    checks++; if (Rs_token !== 6'h22) begin errors++; $display("FAIL fwd_token: got %h expected 22", Rs_token); end
    checks++; if ({Rs_Data_valid, Rs_Data_spec} !== {1'b1, 32'd20}) begin errors++; $display("FAIL fwd_data: got %b/%0d expected 1/20", Rs_Data_valid, Rs_Data_spec); end
    checks++; if (Retire_valid !== 1'b0) begin errors++; $display("FAIL fwd_head_blocked: got %b expected 0", Retire_valid); end
  endtask

  task automatic test_in_order_retire();
    cdb(5'd0, 32'd0, 0, 0);
    Cdb_rd_tag = 5'd1; Cdb_valid = 1; Cdb_data = 32'd10;
    settle();
    checks++; if ({Retire_valid, Retire_rd_tag, Retire_data} !== {1'b1, 5'd0, 32'd0}) begin errors++; $display("FAIL retire0: got %b/%0d/%0d expected 1/0/0", Retire_valid, Retire_rd_tag, Retire_data); end
    tick();
    idle_inputs();
    Rs_reg = 5'd1; Rs_reg_ren = 1;
    settle();
    checks++; if ({Retire_valid, Retire_rd_tag, Retire_data} !== {1'b1, 5'd1, 32'd10}) begin errors++; $display("FAIL retire1: got %b/%0d/%0d expected 1/1/10", Retire_valid, Retire_rd_tag, Retire_data); end
    checks++; if (Rs_token !== 6'h00) begin errors++; $display("FAIL status_cleared: got %h expected 00", Rs_token); end
    tick();
    settle();
    checks++; if ({Retire_valid, Retire_rd_tag, Retire_rd_reg, Retire_data} !== {1'b1, 5'd2, 5'd3, 32'd20}) begin errors++; $display("FAIL retire2: got %b/%0d/%0d/%0d expected 1/2/3/20", Retire_valid, Retire_rd_tag, Retire_rd_reg, Retire_data); end
    tick();
    settle();
    checks++; if (Retire_valid !== 1'b0) begin errors++; $display("FAIL retire_stall: got %b expected 0", Retire_valid); end
  endtask

  task automatic test_store();
    dispatch(5'd5, 5'd0, 32'h100, 2'b10);
    cdb(5'd3, 32'd33, 0, 0);
    cdb(5'd4, 32'd44, 0, 0);
    cdb(5'd5, 32'd55, 0, 0);
    idle_inputs();
    settle();
    checks++; if ({Retire_valid, Retire_store_ready, Retire_rd_tag, Retire_pc} !== {1'b1, 1'b1, 5'd5, 32'h100}) begin errors++; $display("FAIL store_retire: got %b/%b/%0d/%h expected 1/1/5/100", Retire_valid, Retire_store_ready, Retire_rd_tag, Retire_pc); end
    tick();
    settle();
    checks++; if (Retire_valid !== 1'b0) begin errors++; $display("FAIL store_empty: got %b expected 0", Retire_valid); end
  endtask

  task automatic test_full_wrap();
    int nret;
    do_reset();
    for (int i = 0; i < 32; i++) dispatch(5'(i), 5'($urandom_range(31, 1)), 32'(i * 4), 2'b11);
    nret = 0;
    for (int i = 0; i < 100 && nret < 32; i++) begin
      idle_inputs();
      if (i < 32) begin Cdb_rd_tag = 5'(i); Cdb_valid = 1; Cdb_data = 32'(i * 3); end
      settle();
      if (Retire_valid) begin
        checks++; if (Retire_rd_tag !== 5'(nret)) begin errors++; $display("FAIL wrap_order: got %0d expected %0d", Retire_rd_tag, nret); end
        nret++;
      end
      tick();
    end
    checks++; if (nret != 32) begin errors++; $display("FAIL wrap_count: got %0d expected 32", nret); end
    dispatch(5'd0, 5'd9, 32'h40, 2'b01);
    cdb(5'd0, 32'd0, 1, 1);
    idle_inputs();
    settle();
    checks++; if ({Retire_valid, Retire_rd_tag, Retire_branch, Retire_branch_taken} !== {1'b1, 5'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL wrap_head0: got %b/%0d/%b/%b expected 1/0/1/1", Retire_valid, Retire_rd_tag, Retire_branch, Retire_branch_taken); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0]  etok;
    logic [31:0] edat;
    logic        ev;
    int          cand[$];
    int          t;
    bit          ret, inq;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      ret = (q.size() > 0 && q[0].done);
      if ($urandom_range(3, 0) != 0 && (q.size() < 32 || ret)) begin
        Dispatch_inst_type = 2'($urandom_range(3, 0));
        Dispatch_Rd_tag = next_tag; Dispatch_Rd_reg = 5'($urandom_range(7, 0)); Dispatch_pc = $urandom;
        if (Dispatch_inst_type != 2'b00) next_tag = next_tag + 5'd1;
      end
      cand.delete();
      foreach (q[i]) if (!q[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1, 0) == 1) begin
        Cdb_valid = 1; Cdb_rd_tag = q[cand[$urandom_range(cand.size() - 1, 0)]].tag;
      end else if ($urandom_range(9, 0) == 0) begin
        t = $urandom_range(31, 0); inq = 0;
        foreach (q[i]) if (q[i].tag == 5'(t)) inq = 1;
        if (!inq) begin Cdb_valid = 1; Cdb_rd_tag = 5'(t); end
      end
      Cdb_data = $urandom; Cdb_branch = 1'($urandom); Cdb_branch_taken = 1'($urandom);
      Rs_reg = 5'($urandom_range(7, 0)); Rs_reg_ren = 1'($urandom_range(7, 0) != 0);
      Rt_reg = 5'($urandom_range(7, 0)); Rt_reg_ren = 1'($urandom_range(7, 0) != 0);
      settle();
      checks++; if (dut_retire() !== m_retire()) begin errors++; $display("FAIL rand_retire c=%0d: got %h expected %h", c, dut_retire(), m_retire()); end
      m_lookup(Rs_reg, Rs_reg_ren, etok, edat, ev);
      checks++; if ({Rs_token, Rs_Data_spec, Rs_Data_valid} !== {etok, edat, ev}) begin errors++; $display("FAIL rand_rs c=%0d: got %h/%h/%b expected %h/%h/%b", c, Rs_token, Rs_Data_spec, Rs_Data_valid, etok, edat, ev); end
      m_lookup(Rt_reg, Rt_reg_ren, etok, edat, ev);
      checks++; if ({Rt_token, Rt_Data_spec, Rt_Data_valid} !== {etok, edat, ev}) begin errors++; $display("FAIL rand_rt c=%0d: got %h/%h/%b expected %h/%h/%b", c, Rt_token, Rt_Data_spec, Rt_Data_valid, etok, edat, ev); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dispatch(5'd0, 5'd4, 32'h80, 2'b11);
    cdb(5'd0, 32'd77, 0, 0);
    idle_inputs();
    Rs_reg = 5'd4; Rs_reg_ren = 1;
    settle();
    checks++; if ({Retire_valid, Rs_token} !== {1'b1, 6'h20}) begin errors++; $display("FAIL areset_pre: got %b/%h expected 1/20", Retire_valid, Rs_token); end
    #1 reset = 1'b0;
    #1;
    checks++; if (dut_retire() !== 78'd0) begin errors++; $display("FAIL areset_retire: got %h expected 0", dut_retire()); end
    checks++; if (Rs_token !== 6'h00) begin errors++; $display("FAIL areset_token: got %h expected 00", Rs_token); end
    @(posedge clock);
    #1 reset = 1'b1;
    q.delete();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    next_tag = '0;
    test_reset();
    test_dispatch_lookup();
    test_cdb_forward();
    test_in_order_retire();
    test_store();
    test_full_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
